// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encodings and iteration count for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: whole 2*WIDTH product for multiplies,
// independent per-word negation (quotient/remainder or operand pair) otherwise.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] mag_hi,
  input  logic [WIDTH-1:0] mag_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0]   hi_neg_s;
  logic [WIDTH-1:0]   lo_neg_s;

  assign prod_s     = {mag_hi, mag_lo};
  assign prod_neg_s = (~prod_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign hi_neg_s   = (~mag_hi) + {{(WIDTH-1){1'b0}}, 1'b1};
  assign lo_neg_s   = (~mag_lo) + {{(WIDTH-1){1'b0}}, 1'b1};

  // Select the corrected words according to the op class
  always_comb begin
    fix_hi = mag_hi;
    fix_lo = mag_lo;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        if (neg_lo) begin
          {fix_hi, fix_lo} = prod_neg_s;
        end else begin
          {fix_hi, fix_lo} = prod_s;
        end
      end
      default: begin
        fix_hi = neg_hi ? hi_neg_s : mag_hi;
        fix_lo = neg_lo ? lo_neg_s : mag_lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per cycle, with sign correction in a final state.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mduControl,
  input  logic [WIDTH-1:0] var1,
  input  logic [WIDTH-1:0] var2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  logic [1:0]         state_r;
  logic [4:0]         count_r;
  logic [2:0]         op_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic               qsign_r;
  logic               rsign_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               signed_op_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic               div_zero_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign signed_op_s = (mduControl == MDU_MULT) || (mduControl == MDU_DIV);
  assign neg_a_s     = signed_op_s & var1[WIDTH-1];
  assign neg_b_s     = signed_op_s & var2[WIDTH-1];
  assign div_zero_s  = (var2 == {WIDTH{1'b0}});

  mdu_sign_fix #(.WIDTH(WIDTH)) u_operand_mag (
    .op     (MDU_DIV),
    .mag_hi (var1),
    .mag_lo (var2),
    .neg_hi (neg_a_s),
    .neg_lo (neg_b_s),
    .fix_hi (mag_a_s),
    .fix_lo (mag_b_s)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .op     (op_r),
    .mag_hi (acc_r[2*WIDTH-1:WIDTH]),
    .mag_lo (acc_r[WIDTH-1:0]),
    .neg_hi (rsign_r),
    .neg_lo (qsign_r),
    .fix_hi (fix_hi_s),
    .fix_lo (fix_lo_s)
  );

  // Multiply step: accumulator upper half plus multiplicand when LSB set, then shift right
  assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
  assign mul_next_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[2*WIDTH-1:1]};

  // Divide step: remainder sits in the upper half, dividend/quotient bits in the lower half
  assign div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opb_r};
  assign div_next_s  = div_trial_s[WIDTH] ? {acc_r[2*WIDTH-2:0], 1'b0}
                                          : {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

  // FSM, iterative datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      count_r <= 5'd0;
      op_r    <= 3'd0;
      acc_r   <= {(2*WIDTH){1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      qsign_r <= 1'b0;
      rsign_r <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            case (mduControl)
              MDU_MULT, MDU_MULTU: begin
                op_r    <= mduControl;
                acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
                opb_r   <= mag_a_s;
                qsign_r <= neg_a_s ^ neg_b_s;
                rsign_r <= 1'b0;
                count_r <= 5'd0;
                busy_r  <= 1'b1;
                state_r <= S_CALC;
              end
              MDU_DIV, MDU_DIVU: begin
                // A zero divisor leaves the all-ones quotient uncorrected; the remainder restores var1
                op_r    <= mduControl;
                acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
                opb_r   <= mag_b_s;
                qsign_r <= (neg_a_s ^ neg_b_s) & ~div_zero_s;
                rsign_r <= neg_a_s;
                count_r <= 5'd0;
                busy_r  <= 1'b1;
                state_r <= S_CALC;
              end
              MDU_MTHI: hi_r <= var1;
              MDU_MTLO: lo_r <= var1;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc_r <= op_r[1] ? div_next_s : mul_next_s;
          if (count_r == LAST_ITER) begin
            count_r <= 5'd0;
            state_r <= S_FIX;
          end else begin
            count_r <= count_r + 5'd1;
          end
        end
        S_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
